shiftreg_word_serializer: RTL and testbench

Downstream consumer of the iCE40UP div-mode shift register. It takes the register's phase0 output as the word-boundary reference and serialises 4/5/7-bit parallel words LSB-first, one bit per clk. A 2-entry input FIFO with valid/ready handshake feeds it. It checks phase0 periodicity against the selected divide mode, reports lock, and sends an idle word on underflow.

---
 rtl/shiftreg_word_serializer.sv | 128 ++++++++++++
 tb/tb_shiftreg_word_serializer.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/shiftreg_word_serializer.sv
// Serialises 4/5/7-bit words LSB-first, aligned to the upstream shift register's phase0.
// A 2-deep FIFO feeds it; the phase0 period is checked against the divide mode to report lock.
module shiftreg_word_serializer #(
  parameter int                 DATA_W     = 7,
  parameter logic [DATA_W-1:0]  IDLE_WORD  = DATA_W'(7'b1100011),
  parameter int                 LOCK_COUNT = 4,
  parameter int                 UFLOW_W    = 8
) (
  input  logic               clk,
  input  logic               init,
  input  logic [1:0]         shiftregister_div_mode_sel,
  input  logic               phase0,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic               serial_out,
  output logic               word_start,
  output logic               locked,
  output logic               mode_err,
  output logic [UFLOW_W-1:0] underflow_cnt
);

  localparam logic [3:0] LOCK_CNT = 4'(LOCK_COUNT);

  logic [3:0]        n_bits;
  logic              mode_bad;
  logic [DATA_W-1:0] word_mask;
  logic              phase0_q;
  logic              strobe;
  logic [3:0]        per_cnt;
  logic [3:0]        match_cnt;
  logic [3:0]        match_cnt_nxt;
  logic              match;
  logic              load_ok;
  logic              push;
  logic              pop;
  logic              uflow_inc;
  logic [DATA_W-1:0] shifter;
  logic [DATA_W-1:0] fifo_mem0;
  logic [DATA_W-1:0] fifo_mem1;
  logic [1:0]        fifo_cnt;

  // Mode 10 has no defined width; 7 keeps the mask harmless while match is suppressed.
  always_comb begin
    n_bits   = 4'd7;
    mode_bad = 1'b0;
    case (shiftregister_div_mode_sel)
      2'b00:   n_bits = 4'd4;
      2'b01:   n_bits = 4'd7;
      2'b11:   n_bits = 4'd5;
      default: mode_bad = 1'b1;
    endcase
  end

  assign word_mask = ~({DATA_W{1'b1}} << n_bits);
  assign strobe    = phase0 & ~phase0_q;
  assign match     = (per_cnt == n_bits) & ~mode_err & ~mode_bad;

  always_comb begin
    match_cnt_nxt = match_cnt;
    if (strobe) begin
      if (match)
        match_cnt_nxt = (match_cnt >= LOCK_CNT) ? LOCK_CNT : match_cnt + 4'd1;
      else
        match_cnt_nxt = '0;
    end else if (per_cnt == 4'd15) begin
      match_cnt_nxt = '0;
    end
  end

  // An illegal mode loads like the unlocked case: idle word, no pop, no underflow count.
  assign load_ok   = locked & ~mode_err & ~mode_bad;
  assign pop       = strobe & load_ok & (fifo_cnt != 2'd0);
  assign uflow_inc = strobe & load_ok & (fifo_cnt == 2'd0);
  assign in_ready  = (fifo_cnt != 2'd2);
  assign push      = in_valid & in_ready;
  assign serial_out = shifter[0];

  always_ff @(posedge clk) begin
    if (init) begin
      phase0_q      <= 1'b0;
      per_cnt       <= '0;
      match_cnt     <= '0;
      locked        <= 1'b0;
      mode_err      <= 1'b0;
      word_start    <= 1'b0;
      shifter       <= '0;
      underflow_cnt <= '0;
    end else begin
      phase0_q   <= phase0;
      mode_err   <= mode_bad;
      per_cnt    <= strobe ? 4'd1 : ((per_cnt == 4'd15) ? per_cnt : per_cnt + 4'd1);
      match_cnt  <= match_cnt_nxt;
      locked     <= (match_cnt_nxt == LOCK_CNT);
      word_start <= strobe;
      if (strobe)
        shifter <= (pop ? fifo_mem0 : IDLE_WORD) & word_mask;
      else
        shifter <= shifter >> 1;
      if (uflow_inc && (underflow_cnt != '1))
        underflow_cnt <= underflow_cnt + 1'b1;
    end
  end

  // Push and pop together only happen at count 1, where the new word becomes the head.
  always_ff @(posedge clk) begin
    if (init) begin
      fifo_cnt  <= '0;
      fifo_mem0 <= '0;
      fifo_mem1 <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) fifo_mem0 <= in_data;
          else                  fifo_mem1 <= in_data;
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          fifo_mem0 <= fifo_mem1;
          fifo_cnt  <= fifo_cnt - 2'd1;
        end
        2'b11: fifo_mem0 <= in_data;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shiftreg_word_serializer.sv
// Self-checking bench: directed mode/period scenarios plus random data, compared against
// a queue-based reference model that tracks the current word and bit position.
module tb_shiftreg_word_serializer;
  localparam int         DATA_W = 7;
  localparam int         LC     = 4;
  localparam int         IDLE   = 7'b1100011;

  logic              clk = 1'b0;
  logic              init;
  logic [1:0]        sel;
  logic              phase0;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              serial_out;
  logic              word_start;
  logic              locked;
  logic              mode_err;
  logic [7:0]        underflow_cnt;

  always #5 clk = ~clk;

  shiftreg_word_serializer dut (
    .clk                        (clk),
    .init                       (init),
    .shiftregister_div_mode_sel (sel),
    .phase0                     (phase0),
    .in_data                    (in_data),
    .in_valid                   (in_valid),
    .in_ready                   (in_ready),
    .serial_out                 (serial_out),
    .word_start                 (word_start),
    .locked                     (locked),
    .mode_err                   (mode_err),
    .underflow_cnt              (underflow_cnt)
  );

  int ncmp = 0;
  int nerr = 0;

  // reference model: FIFO as a queue, current word plus index of the bit on the line
  int q[$];
  int m_ph_q, m_per, m_match, m_locked, m_merr, m_uflow, m_word, m_idx, m_ws;
  int ph_cnt;
  bit alt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ph_q = 0; m_per = 0; m_match = 0; m_locked = 0; m_merr = 0;
    m_uflow = 0; m_word = 0; m_idx = 0; m_ws = 0;
  endtask

  task automatic model_step(input bit [1:0] s, input bit ph, input bit vin, input int din);
    int  n, new_match, w;
    bit  bad, strobe, can_load, ready;
    bad      = (s == 2'b10);
    n        = (s == 2'b00) ? 4 : (s == 2'b11) ? 5 : 7;
    strobe   = ph && (m_ph_q == 0);
    can_load = (m_locked != 0) && (m_merr == 0) && !bad;
    ready    = q.size() < 2;
    if (strobe) begin
      if (m_per == n && m_merr == 0 && !bad)
        new_match = (m_match < LC) ? m_match + 1 : LC;
      else
        new_match = 0;
      if (can_load && q.size() > 0) begin
        w = q.pop_front();
      end else begin
        w = IDLE;
        if (can_load && m_uflow < 255) m_uflow++;
      end
      m_word = w % (1 << n);
      m_idx  = 0;
      m_ws   = 1;
    end else begin
      new_match = (m_per == 15) ? 0 : m_match;
      if (m_idx < 31) m_idx++;
      m_ws = 0;
    end
    m_per    = strobe ? 1 : ((m_per < 15) ? m_per + 1 : 15);
    m_match  = new_match;
    m_locked = (new_match == LC) ? 1 : 0;
    m_merr   = bad ? 1 : 0;
    m_ph_q   = ph ? 1 : 0;
    if (vin && ready) q.push_back(din);
  endtask

  task automatic tick(input bit i_init, input bit [1:0] s, input bit ph, input bit vin,
                      input bit [DATA_W-1:0] din);
    init = i_init; sel = s; phase0 = ph; in_valid = vin; in_data = din;
    if (i_init) model_reset();
    else        model_step(s, ph, vin, int'(din));
    @(posedge clk);
    #1;
    check("serial_out",    serial_out,    (m_word >> m_idx) & 1);
    check("word_start",    word_start,    m_ws);
    check("locked",        locked,        m_locked);
    check("mode_err",      mode_err,      m_merr);
    check("underflow_cnt", underflow_cnt, m_uflow);
    check("in_ready",      in_ready,      (q.size() < 2) ? 1 : 0);
  endtask

  // vmode: 0 idle, 1 always valid, 2 valid with alternating 55/2A, 3 random valid
  task automatic run(input bit [1:0] s, input int period, input int cycles, input int vmode);
    bit              ph, vin, acc;
    bit [DATA_W-1:0] din;
    ph_cnt = 0;
    for (int i = 0; i < cycles; i++) begin
      ph = (ph_cnt % period) == 0;
      ph_cnt++;
      din = DATA_W'($urandom);
      case (vmode)
        0: vin = 1'b0;
        1: vin = 1'b1;
        2: begin vin = 1'b1; din = alt ? 7'h2A : 7'h55; end
        default: vin = $urandom_range(0, 1) != 0;
      endcase
      acc = q.size() < 2;
      tick(1'b0, s, ph, vin, din);
      if (vmode == 2 && acc) alt = ~alt;
    end
  endtask

  initial begin
    bit [1:0] rs;
    int       rp;
    alt = 1'b0;
    init = 1'b1; sel = 2'b01; phase0 = 1'b0; in_valid = 1'b0; in_data = '0;
    model_reset();
    tick(1'b1, 2'b01, 1'b0, 1'b1, 7'h11);
    tick(1'b1, 2'b01, 1'b1, 1'b1, 7'h22);
    check("rst_in_ready", in_ready, 1);
    check("rst_serial",   serial_out, 0);
    check("rst_locked",   locked, 0);

    // mode 01, period 7, alternating 55/2A
    run(2'b01, 7, 8 * 7, 2);
    check("lock_mode01", locked, 1);
    run(2'b01, 7, 6 * 7, 1);

    // mode 00, period 4: relock, one word then underflow to saturation
    run(2'b00, 4, 24, 0);
    check("relock_mode00", locked, 1);
    tick(1'b0, 2'b00, 1'b0, 1'b1, 7'h7A);
    run(2'b00, 4, 4 * 270, 0);
    check("uflow_sat", underflow_cnt, 255);

    // mode 11, period 5, FIFO kept full
    run(2'b11, 5, 5 * 10, 1);
    check("full_in_ready", in_ready, 0);

    // illegal mode: no lock, no drain
    run(2'b10, 5, 30, 1);
    check("illegal_err",   mode_err, 1);
    check("illegal_lock",  locked, 0);
    check("illegal_full",  in_ready, 0);

    // phase0 stuck low while locked
    run(2'b01, 7, 7 * 7, 3);
    check("lock_before_stuck", locked, 1);
    for (int i = 0; i < 16; i++) tick(1'b0, 2'b01, 1'b0, 1'b0, '0);
    check("stuck_unlock", locked, 0);

    // reset mid-word
    run(2'b01, 7, 7 * 7, 1);
    run(2'b01, 7, 3, 1);
    tick(1'b1, 2'b01, 1'b0, 1'b1, 7'h3C);
    check("midrst_serial",   serial_out, 0);
    check("midrst_in_ready", in_ready, 1);
    tick(1'b0, 2'b01, 1'b0, 1'b0, '0);

    // random segments over the legal modes
    for (int k = 0; k < 20; k++) begin
      case ($urandom_range(0, 2))
        0:       rs = 2'b00;
        1:       rs = 2'b01;
        default: rs = 2'b11;
      endcase
      if ($urandom_range(0, 3) != 0) rp = (rs == 2'b00) ? 4 : (rs == 2'b11) ? 5 : 7;
      else                           rp = $urandom_range(3, 9);
      run(rs, rp, $urandom_range(30, 80), $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
